spi_frame_counter: RTL and testbench
====================================

// Module: spi_frame_counter
// PURPOSE
//  Parametrised SPI slave bit/frame counter: counts serial bits against a runtime-loadable frame length.
//  Flags the last bit and frame completion, and counts completed frames.
//  Supports continuous (back-to-back) and single-shot modes and flags frames aborted by SS_n or start.
//  Sits between the SPI slave FSM (drives start, bit_en) and the shift register / rx_valid logic.
// PARAMETERS
//  CNT_W        5   width of bit counter and frame-length register (max frame 2**CNT_W-1 bits)
//  DEFAULT_LEN  10  frame length (bits) after reset; must be 1..2**CNT_W-1
//  FRM_CNT_W    8   width of completed-frame counter
// PORTS
//  clk        in   1          clock; all logic on posedge
//  rst_n      in   1          reset, synchronous, active-low
//  ss_n       in   1          SPI slave select, active-low (pre-synchronised)
//  start      in   1          from slave FSM: counting permitted while high
//  bit_en     in   1          one-cycle strobe per sampled SPI bit
//  len_load   in   1          load len_in into frame-length register
//  len_in     in   CNT_W      new frame length in bits
//  mode_stop  in   1          1 = single-shot (HOLD after frame), 0 = continuous
//  err_clr    in   1          clears short_err
//  count      out  CNT_W      bits counted in current frame (0..len-1)
//  last_bit   out  1          comb: state==COUNT && count==len_r-1
//  done       out  1          registered 1-cycle pulse, cycle after final bit_en of a frame
//  busy       out  1          state != IDLE
//  frame_cnt  out  FRM_CNT_W  completed frames, wraps modulo 2**FRM_CNT_W
//  short_err  out  1          sticky: frame aborted with count != 0
// BEHAVIOUR
//  Reset: state=IDLE, count=0, len_r=DEFAULT_LEN, done=0, frame_cnt=0, short_err=0.
//  States: IDLE, COUNT, HOLD.
//  - IDLE -> COUNT when !ss_n && start; count stays 0.
//  - COUNT, bit_en, count<len_r-1: count+1.
//  - COUNT, bit_en, count==len_r-1: done=1 next cycle; frame_cnt+1.
//    mode_stop=0: count<=0, stay COUNT. mode_stop=1: count<=0, -> HOLD.
//  - HOLD: bit_en ignored; -> IDLE when ss_n || !start.
//  Abort: in COUNT or HOLD, ss_n=1 or start=0 -> IDLE, count<=0.
//    If aborted from COUNT with count!=0, short_err<=1.
//  Priority: rst_n > abort > bit_en. An abort in the same cycle as bit_en drops the bit (no done, no frame_cnt).
//  len_load accepted only in IDLE. len_in==0 ignored (len_r unchanged). Loads in COUNT/HOLD ignored.
//  len_r==1: every bit_en in COUNT completes a frame; last_bit=1 for the whole COUNT state.
//  frame_cnt wraps all-ones -> 0 silently.
//  short_err: set has priority over err_clr in the same cycle.
//  done never asserts in IDLE. Back-to-back frames in continuous mode give done every len_r bit_en.
//  Unsigned arithmetic. Compare count against len_r-1 computed in CNT_W bits (len_r >= 1, so no underflow).
// STRUCTURE
//  spi_pkg: state enum (IDLE/COUNT/HOLD), SPI_DEFAULT_FRAME_LEN=10 constant.
//  Single module, no sub-module: FSM + count + len_r + frame_cnt + error flag.
// TESTING
//  1. Reset, ss_n=0, start=1, 10 bit_en, mode_stop=0 -> done after 10th; count 0..9,0; frame_cnt=1.
//  2. len_load len_in=3 in IDLE, mode_stop=1, 5 bit_en -> one done after 3rd; state HOLD; count stays 0.
//  3. ss_n rises after 4 of 10 bits -> IDLE, count=0, short_err=1, no done; err_clr -> short_err=0.
//  4. ss_n rises in the same cycle as the 10th bit_en -> no done, frame_cnt unchanged, short_err=1.
//  5. len_load in COUNT and len_in=0 in IDLE -> len_r unchanged (10); len_in=1 -> done every bit_en.
//  6. FRM_CNT_W=2, 5 frames back-to-back -> frame_cnt 1,2,3,0,1; rst_n low mid-frame -> all reset values.

Source files
------------

// File: rtl/spi_frame_counter_pkg.sv
// Shared types and constants for the SPI slave frame counter.
package spi_frame_counter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    HOLD  = 2'd2
  } frame_state_e;

  localparam int SPI_DEFAULT_FRAME_LEN = 10;

endpackage

// File: rtl/spi_frame_counter.sv
// SPI slave bit/frame counter: counts sampled bits against a loadable frame length,
// flags the last bit and frame completion, counts frames and latches aborted frames.
module spi_frame_counter
  import spi_frame_counter_pkg::*;
#(
  parameter int CNT_W       = 5,
  parameter int DEFAULT_LEN = SPI_DEFAULT_FRAME_LEN,
  parameter int FRM_CNT_W   = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 ss_n_i,
  input  logic                 start_i,
  input  logic                 bit_en_i,
  input  logic                 len_load_i,
  input  logic [CNT_W-1:0]     len_in_i,
  input  logic                 mode_stop_i,
  input  logic                 err_clr_i,
  output logic [CNT_W-1:0]     count_o,
  output logic                 last_bit_o,
  output logic                 done_o,
  output logic                 busy_o,
  output logic [FRM_CNT_W-1:0] frame_cnt_o,
  output logic                 short_err_o
);

  frame_state_e           state_q, state_d;
  logic [CNT_W-1:0]       count_q, count_d;
  logic [CNT_W-1:0]       len_q, len_d;
  logic [FRM_CNT_W-1:0]   frame_cnt_q, frame_cnt_d;
  logic                   done_q, done_d;
  logic                   short_err_q, short_err_d;
  logic [CNT_W-1:0]       len_m1;
  logic                   abort;
  logic                   err_set;

  // len_q is never zero, so len_q-1 cannot underflow.
  assign len_m1 = len_q - CNT_W'(1);
  assign abort  = ss_n_i || !start_i;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      count_q     <= '0;
      len_q       <= CNT_W'(DEFAULT_LEN);
      frame_cnt_q <= '0;
      done_q      <= 1'b0;
      short_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      len_q       <= len_d;
      frame_cnt_q <= frame_cnt_d;
      done_q      <= done_d;
      short_err_q <= short_err_d;
    end
  end

  // Abort outranks bit_en: a bit arriving with ss_n/start dropping is discarded.
  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    len_d       = len_q;
    frame_cnt_d = frame_cnt_q;
    done_d      = 1'b0;
    err_set     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (len_load_i && (len_in_i != '0)) len_d = len_in_i;
        if (!abort) state_d = COUNT;
      end
      COUNT: begin
        if (abort) begin
          state_d = IDLE;
          count_d = '0;
          err_set = (count_q != '0);
        end else if (bit_en_i) begin
          if (count_q == len_m1) begin
            count_d     = '0;
            done_d      = 1'b1;
            frame_cnt_d = frame_cnt_q + FRM_CNT_W'(1);
            if (mode_stop_i) state_d = HOLD;
          end else begin
            count_d = count_q + CNT_W'(1);
          end
        end
      end
      HOLD: begin
        if (abort) begin
          state_d = IDLE;
          count_d = '0;
        end
      end
      default: begin
        state_d = IDLE;
        count_d = '0;
      end
    endcase
    short_err_d = short_err_q;
    if (err_clr_i) short_err_d = 1'b0;
    if (err_set)   short_err_d = 1'b1;
  end

  assign count_o     = count_q;
  assign last_bit_o  = (state_q == COUNT) && (count_q == len_m1);
  assign done_o      = done_q;
  assign busy_o      = (state_q != IDLE);
  assign frame_cnt_o = frame_cnt_q;
  assign short_err_o = short_err_q;

endmodule

// File: tb/tb_spi_frame_counter.sv
// Self-checking bench for spi_frame_counter: directed scenarios followed by random
// traffic, all compared against a frame-level reference model.
module tb_spi_frame_counter;

  localparam int CNT_W     = 5;
  localparam int FRM_CNT_W = 2;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 ss_n;
  logic                 start;
  logic                 bit_en;
  logic                 len_load;
  logic [CNT_W-1:0]     len_in;
  logic                 mode_stop;
  logic                 err_clr;
  logic [CNT_W-1:0]     count;
  logic                 last_bit;
  logic                 done;
  logic                 busy;
  logic [FRM_CNT_W-1:0] frame_cnt;
  logic                 short_err;

  int checks = 0;
  int errors = 0;

  // Reference model: 0 = idle, 1 = receiving a frame, 2 = waiting after a single-shot frame.
  int phase;
  int bits_seen;
  int frame_len;
  int frames;
  bit frame_done;
  bit err_flag;

  spi_frame_counter #(
    .CNT_W      (CNT_W),
    .DEFAULT_LEN(10),
    .FRM_CNT_W  (FRM_CNT_W)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ss_n_i     (ss_n),
    .start_i    (start),
    .bit_en_i   (bit_en),
    .len_load_i (len_load),
    .len_in_i   (len_in),
    .mode_stop_i(mode_stop),
    .err_clr_i  (err_clr),
    .count_o    (count),
    .last_bit_o (last_bit),
    .done_o     (done),
    .busy_o     (busy),
    .frame_cnt_o(frame_cnt),
    .short_err_o(short_err)
  );

  always #5 clk = ~clk;

  task automatic modelStep();
    bit aborted;
    bit set_err;
    aborted    = ss_n || !start;
    set_err    = 1'b0;
    frame_done = 1'b0;
    if (!rst_n) begin
      phase     = 0;
      bits_seen = 0;
      frame_len = 10;
      frames    = 0;
      err_flag  = 1'b0;
      return;
    end
    if (phase == 0) begin
      if (len_load && len_in != 0) frame_len = int'(len_in);
      if (!aborted) phase = 1;
    end else if (phase == 1) begin
      if (aborted) begin
        set_err   = (bits_seen != 0);
        phase     = 0;
        bits_seen = 0;
      end else if (bit_en) begin
        bits_seen++;
        if (bits_seen == frame_len) begin
          bits_seen  = 0;
          frame_done = 1'b1;
          frames     = (frames + 1) % (1 << FRM_CNT_W);
          if (mode_stop) phase = 2;
        end
      end
    end else begin
      if (aborted) phase = 0;
    end
    if (err_clr) err_flag = 1'b0;
    if (set_err) err_flag = 1'b1;
  endtask

  task automatic checkOutput(string tag, logic [31:0] observed, logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%0d expected=%0d at %0t", tag, observed, expected, $time);
    end
  endtask

  // Drive one cycle of inputs, clock it, then compare every output to the model.
  task automatic applyStimulus(input bit s_n, input bit st, input bit ben, input bit ld,
                               input int lin, input bit ms, input bit ec);
    ss_n      = s_n;
    start     = st;
    bit_en    = ben;
    len_load  = ld;
    len_in    = CNT_W'(lin);
    mode_stop = ms;
    err_clr   = ec;
    @(posedge clk);
    modelStep();
    #1;
    checkOutput("count",     32'(count),     32'(bits_seen));
    checkOutput("last_bit",  32'(last_bit),  32'(phase == 1 && bits_seen == frame_len - 1));
    checkOutput("done",      32'(done),      32'(frame_done));
    checkOutput("busy",      32'(busy),      32'(phase != 0));
    checkOutput("frame_cnt", 32'(frame_cnt), 32'(frames));
    checkOutput("short_err", 32'(short_err), 32'(err_flag));
  endtask

  initial begin
    rst_n = 1'b0;
    applyStimulus(1, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 1, 1, 0, 0, 0, 0);
    rst_n = 1'b1;

    // Continuous frame of the default length.
    applyStimulus(0, 1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 10; i++) applyStimulus(0, 1, 1, 0, 0, 0, 0);
    applyStimulus(0, 1, 0, 0, 0, 0, 0);
    applyStimulus(1, 1, 0, 0, 0, 0, 0);

    // Short single-shot frame: extra bits ignored while holding.
    applyStimulus(1, 1, 0, 1, 3, 1, 0);
    applyStimulus(0, 1, 0, 0, 0, 1, 0);
    for (int i = 0; i < 5; i++) applyStimulus(0, 1, 1, 0, 0, 1, 0);
    applyStimulus(0, 0, 0, 0, 0, 1, 0);

    // Abort after four bits, then clear the error.
    applyStimulus(1, 1, 0, 1, 10, 0, 0);
    applyStimulus(0, 1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) applyStimulus(0, 1, 1, 0, 0, 0, 0);
    applyStimulus(1, 1, 0, 0, 0, 0, 0);
    applyStimulus(1, 1, 0, 0, 0, 0, 1);

    // Abort coinciding with the final bit drops it.
    applyStimulus(0, 1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 9; i++) applyStimulus(0, 1, 1, 0, 0, 0, 0);
    applyStimulus(1, 1, 1, 0, 0, 0, 0);
    applyStimulus(1, 1, 0, 0, 0, 0, 1);

    // Loads while counting and zero lengths are ignored; length 1 completes on every bit.
    applyStimulus(0, 1, 0, 0, 0, 0, 0);
    applyStimulus(0, 1, 1, 1, 1, 0, 0);
    applyStimulus(0, 1, 1, 1, 1, 0, 0);
    applyStimulus(1, 1, 0, 0, 0, 0, 1);
    applyStimulus(1, 1, 0, 1, 0, 0, 0);
    applyStimulus(0, 1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 10; i++) applyStimulus(0, 1, 1, 0, 0, 0, 0);
    applyStimulus(1, 1, 0, 1, 1, 0, 0);
    applyStimulus(0, 1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) applyStimulus(0, 1, 1, 0, 0, 0, 0);

    // Reset in the middle of a frame.
    applyStimulus(1, 1, 0, 1, 10, 0, 0);
    applyStimulus(0, 1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) applyStimulus(0, 1, 1, 0, 0, 0, 0);
    rst_n = 1'b0;
    applyStimulus(0, 1, 1, 0, 0, 0, 0);
    rst_n = 1'b1;

    // Random traffic with selects held mostly active so frames complete.
    for (int i = 0; i < 2000; i++) begin
      rst_n = ($urandom_range(0, 499) != 0);
      applyStimulus($urandom_range(0, 19) == 0,
                    $urandom_range(0, 24) != 0,
                    $urandom_range(0, 2) != 0,
                    $urandom_range(0, 5) == 0,
                    int'($urandom_range(0, 7)),
                    $urandom_range(0, 3) == 0,
                    $urandom_range(0, 9) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
